// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store stage and the data memory.
// The master issues requests and consumes responses; the slave is the memory.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_rd;
  logic            rsp_write;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_funct3, req_wdata, req_rd,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_rd, rsp_write, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_funct3, req_wdata, req_rd,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_rd, rsp_write, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory for the load/store path: byte-lane RAM with
// RISC-V sub-word access, load extension and error reporting.
module dmem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]      cnt;
  logic            q_write;
  logic [XLEN-1:0] q_addr;
  logic [XLEN-1:0] q_wdata;
  logic [2:0]      q_f3;
  logic [4:0]      q_rd;

  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic            fire;
  logic            f3_ok;
  logic            misal;
  logic            oor;
  logic            err;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] word;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_data;
  logic [NB-1:0]   be;

  assign accept = (state == IDLE) &&
                  bus.req_valid && bus.req_ready;
  assign fire   = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (fire) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.req_ready <= 1'b0;
    else        bus.req_ready <= (state_nx == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      q_write <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_f3    <= '0;
      q_rd    <= '0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      q_write <= bus.req_write;
      q_addr  <= bus.req_addr;
      q_wdata <= bus.req_wdata;
      q_f3    <= bus.req_funct3;
      q_rd    <= bus.req_rd;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    f3_ok = 1'b0;
    unique case (q_f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !q_write;
      default:                f3_ok = 1'b0;
    endcase
    misal = (q_f3[1:0] == 2'b01 && q_addr[0]) ||
            (q_f3[1:0] == 2'b10 &&
             q_addr[1:0] != 2'b00);
    oor   = |q_addr[XLEN-1:AW+2];
    err   = !f3_ok || misal || oor;
    idx   = q_addr[AW+1:2];
    word  = mem[idx];
    b     = word[{q_addr[1:0], 3'b000} +: 8];
    h     = word[{q_addr[1], 4'b0000} +: 16];
  end

  always_comb begin
    ld_data = word;
    unique case (q_f3)
      3'b000:  ld_data = {{(XLEN-8){b[7]}}, b};
      3'b001:  ld_data = {{(XLEN-16){h[15]}}, h};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, b};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, h};
      default: ld_data = word;
    endcase
  end

  // Store data is replicated across lanes so the enable mask alone picks it.
  always_comb begin
    st_data = q_wdata;
    be      = '1;
    unique case (q_f3[1:0])
      2'b00: begin
        st_data = {NB{q_wdata[7:0]}};
        be      = NB'(1) << q_addr[1:0];
      end
      2'b01: begin
        st_data = {(NB/2){q_wdata[15:0]}};
        be      = NB'(3) << {q_addr[1], 1'b0};
      end
      default: begin
        st_data = q_wdata;
        be      = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (fire && q_write && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_rd    <= '0;
      bus.rsp_write <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else if (fire) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_write <= q_write;
      bus.rsp_err   <= err;
      bus.rsp_rd    <= q_write ? 5'd0 : q_rd;
      bus.rsp_data  <= (q_write || err) ? '0 : ld_data;
    end else if (state == RESP && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_rd    <= '0;
      bus.rsp_write <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array memory model with a per-cycle
// response compare, directed literal checks, latency and reset cases.
module tb_dmem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.XLEN(32)) bus ();
  dmem_responder_if #(.XLEN(32)) bus1 ();
  dmem_responder_if #(.XLEN(32)) bus4 ();

  dmem_responder #(
    .XLEN(32), .DEPTH(DEPTH), .LATENCY(2)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  dmem_responder #(
    .XLEN(32), .DEPTH(DEPTH), .LATENCY(1)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  dmem_responder #(
    .XLEN(32), .DEPTH(DEPTH), .LATENCY(4)
  ) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        w;
    logic        err;
  } exp_t;

  exp_t q[$];
  logic [7:0] mb [4*DEPTH];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Expected response straight from the access rules, byte by byte.
  task automatic predict(input logic w, input logic [31:0] a,
                         input logic [2:0] f3,
                         input logic [31:0] wd,
                         input logic [4:0] rd);
    exp_t e;
    int size;
    logic ok;
    logic [31:0] v;
    size = 1 << f3[1:0];
    ok = w ? (f3 <= 3'd2)
           : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e.err = !ok || (a % size != 0) || ((a >> 2) >= DEPTH);
    e.w = w;
    e.rd = w ? 5'd0 : rd;
    e.data = 32'd0;
    if (!e.err && w)
      for (int i = 0; i < size; i++) mb[a+i] = wd[8*i +: 8];
    if (!e.err && !w) begin
      v = 32'd0;
      for (int i = 0; i < size; i++)
        v = v | (32'(mb[a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1])
        v = v | ~((32'd1 << (8*size)) - 32'd1);
      e.data = v;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rsp: got valid expected none");
      end else begin
        chk("rsp_data", bus.rsp_data, q[0].data);
        chk("rsp_rd", 32'(bus.rsp_rd), 32'(q[0].rd));
        chk("rsp_write", 32'(bus.rsp_write), 32'(q[0].w));
        chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
        if (bus.rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic xact(input logic w, input logic [31:0] a,
                      input logic [2:0] f3,
                      input logic [31:0] wd,
                      input logic [4:0] rd, input int hold,
                      output logic [31:0] d, output logic e,
                      output int lat);
    int n;
    logic [31:0] d0;
    d = '0;
    e = 1'b0;
    lat = -1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) return;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_funct3 = f3;
    bus.req_wdata = wd;
    bus.req_rd = rd;
    bus.req_valid = 1'b1;
    predict(w, a, f3, wd, rd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    if (!bus.rsp_valid) return;
    lat = n;
    d0 = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", bus.rsp_data, d0);
      @(posedge clk); #1;
    end
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("valid_clear", 32'(bus.rsp_valid), 32'd0);
    chk("ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  // Same request to the latency-1 and latency-4 instances at once.
  task automatic aux_pair(input logic w, input logic [31:0] a,
                          input logic [2:0] f3,
                          input logic [31:0] wd,
                          output int l1, output int l4,
                          output logic [31:0] d1,
                          output logic [31:0] d4);
    l1 = -1;
    l4 = -1;
    d1 = '0;
    d4 = '0;
    chk("aux1_ready", 32'(bus1.req_ready), 32'd1);
    chk("aux4_ready", 32'(bus4.req_ready), 32'd1);
    bus1.req_write = w;  bus4.req_write = w;
    bus1.req_addr = a;   bus4.req_addr = a;
    bus1.req_funct3 = f3; bus4.req_funct3 = f3;
    bus1.req_wdata = wd; bus4.req_wdata = wd;
    bus1.req_rd = 5'd3;  bus4.req_rd = 5'd3;
    bus1.req_valid = 1'b1;
    bus4.req_valid = 1'b1;
    bus1.rsp_ready = 1'b1;
    bus4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    bus4.req_valid = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (bus1.rsp_valid && l1 < 0) begin
        l1 = c; d1 = bus1.rsp_data;
      end
      if (bus4.rsp_valid && l4 < 0) begin
        l4 = c; d4 = bus4.rsp_data;
      end
      @(posedge clk); #1;
    end
    bus1.rsp_ready = 1'b0;
    bus4.rsp_ready = 1'b0;
  endtask

  logic [31:0] d, d1, d4;
  logic e;
  int lat, l1, l4;

  initial begin
    bus.req_valid = 0;  bus.req_write = 0;
    bus.req_addr = 0;   bus.req_funct3 = 0;
    bus.req_wdata = 0;  bus.req_rd = 0;
    bus.rsp_ready = 0;
    bus1.req_valid = 0; bus1.req_write = 0;
    bus1.req_addr = 0;  bus1.req_funct3 = 0;
    bus1.req_wdata = 0; bus1.req_rd = 0;
    bus1.rsp_ready = 0;
    bus4.req_valid = 0; bus4.req_write = 0;
    bus4.req_addr = 0;  bus4.req_funct3 = 0;
    bus4.req_wdata = 0; bus4.req_rd = 0;
    bus4.rsp_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    chk("valid_after_rst", 32'(bus.rsp_valid), 32'd0);

    xact(1, 32'h10, 3'b010, 32'hDEADBEEF, 5'd0, 0, d, e, lat);
    chk("lat_main", 32'(lat), 32'd2);
    xact(0, 32'h10, 3'b010, 0, 5'd5, 0, d, e, lat);
    chk("lw_10", d, 32'hDEADBEEF);
    chk("lw_10_err", 32'(e), 32'd0);
    chk("rd_echo", 32'(bus.rsp_rd), 32'd0);

    xact(0, 32'h13, 3'b000, 0, 5'd6, 0, d, e, lat);
    chk("lb_13", d, 32'hFFFFFFDE);
    xact(0, 32'h13, 3'b100, 0, 5'd6, 0, d, e, lat);
    chk("lbu_13", d, 32'h000000DE);
    xact(0, 32'h12, 3'b001, 0, 5'd6, 0, d, e, lat);
    chk("lh_12", d, 32'hFFFFDEAD);
    xact(0, 32'h10, 3'b101, 0, 5'd6, 0, d, e, lat);
    chk("lhu_10", d, 32'h0000BEEF);

    xact(1, 32'h11, 3'b000, 32'h55, 5'd0, 0, d, e, lat);
    xact(0, 32'h10, 3'b010, 0, 5'd7, 0, d, e, lat);
    chk("sb_11", d, 32'hDEAD55EF);
    xact(1, 32'h12, 3'b001, 32'h1234, 5'd0, 0, d, e, lat);
    xact(0, 32'h10, 3'b010, 0, 5'd7, 0, d, e, lat);
    chk("sh_12", d, 32'h123455EF);

    xact(0, 32'h12, 3'b010, 0, 5'd8, 0, d, e, lat);
    chk("lw_mis_err", 32'(e), 32'd1);
    chk("lw_mis_data", d, 32'd0);
    xact(1, 32'h13, 3'b001, 32'hFFFF, 5'd8, 0, d, e, lat);
    chk("sh_mis_err", 32'(e), 32'd1);
    xact(0, 32'(4*DEPTH), 3'b010, 0, 5'd9, 0, d, e, lat);
    chk("lw_oor_err", 32'(e), 32'd1);
    chk("lw_oor_data", d, 32'd0);
    xact(0, 32'h10, 3'b011, 0, 5'd9, 0, d, e, lat);
    chk("f3_011_err", 32'(e), 32'd1);
    xact(1, 32'h12, 3'b010, 32'hFFFFFFFF, 5'd0, 0, d, e, lat);
    chk("sw_mis_err", 32'(e), 32'd1);
    xact(0, 32'h10, 3'b010, 0, 5'd10, 0, d, e, lat);
    chk("no_err_write", d, 32'h123455EF);

    xact(0, 32'h12, 3'b001, 0, 5'd11, 5, d, e, lat);
    chk("bp_data", d, 32'h00001234);
    chk("bp_lat", 32'(lat), 32'd2);

    aux_pair(1, 32'h40, 3'b010, 32'hCAFEF00D, l1, l4, d1, d4);
    chk("lat1_sw", 32'(l1), 32'd1);
    chk("lat4_sw", 32'(l4), 32'd4);
    aux_pair(0, 32'h40, 3'b010, 0, l1, l4, d1, d4);
    chk("lat1_lw", 32'(l1), 32'd1);
    chk("lat4_lw", 32'(l4), 32'd4);
    chk("lat1_data", d1, 32'hCAFEF00D);
    chk("lat4_data", d4, 32'hCAFEF00D);

    xact(1, 32'h20, 3'b010, 32'h11223344, 5'd0, 0, d, e, lat);
    bus.req_write = 1;
    bus.req_addr = 32'h20;
    bus.req_funct3 = 3'b010;
    bus.req_wdata = 32'hA5A5A5A5;
    bus.req_rd = 5'd0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("dropped_valid", 32'(bus.rsp_valid), 32'd0);
    end
    xact(0, 32'h20, 3'b010, 0, 5'd12, 0, d, e, lat);
    chk("dropped_sw", d, 32'h11223344);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
